bus_arb2: RTL and testbench

Two-master arbiter and sequencer for the internal register bus. It sits between two requesters, the host interface (master 0) and the on-chip sequencer (master 1), and the shared `bus_in`/`bus_out` fabric that all register slaves decode. It grants one master at a time in round-robin order and issues exactly one single-cycle bus request per transaction. It then waits for the matching registered acknowledge from the slave and returns read data, with an optional timeout, to the granted master.

---
 rtl/bus_arb2.sv | 235 +++++++++++++++++++++++
 tb/tb_bus_arb2.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// bus_arb2 -- two-master round-robin arbiter and sequencer for the register bus.
// Latency: request seen in IDLE at T, bus request at T+1, mN_ack at T+3 at the earliest.
// Backpressure: masters hold mN_req until mN_ack; slow slaves stretch WAIT one cycle per cycle of ack delay.
//
// Ports:
//   bus_clk, bus_reset_l   clock and synchronous active-low reset
//   bus_in                 packed request bus to the slaves (clock, reset, rd/wr request, address, write data)
//   bus_out                OR of all slave outputs (read data, rd_ack, wr_ack, irq; irq is not used here)
//   mN_req/we/addr/wdata   master N transaction request, held stable until mN_ack
//   mN_ack/rdata/err       master N one-cycle completion pulse, read data (held), timeout flag
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to build the WAIT-state timeout counter.
// Without it WAIT lasts until the matching ack arrives and mN_err is tied low.
//
// Bus field layout. Kept here behind an include guard so this file stands alone
// but still agrees with any shared bus_params.v that defines the same guard.

`ifndef BUS_PARAMS_V
`define BUS_PARAMS_V
`define BUS_ADDR_WIDTH    12
`define BUS_DATA_WIDTH    32
`define BUS_IN_WIDTH      48
`define BUS_OUT_WIDTH     35
`define BUS_IN_CLK        0
`define BUS_IN_RESET_L    1
`define BUS_IN_RD_REQ     2
`define BUS_IN_WR_REQ     3
`define BUS_IN_ADDR_LO    4
`define BUS_IN_ADDR_HI    15
`define BUS_IN_WDATA_LO   16
`define BUS_IN_WDATA_HI   47
`define BUS_OUT_RDATA_LO  0
`define BUS_OUT_RDATA_HI  31
`define BUS_OUT_RD_ACK    32
`define BUS_OUT_WR_ACK    33
`define BUS_OUT_IRQ       34
`endif

module bus_arb2 #(
   parameter int TIMEOUT = 255
) (
   input  logic                        bus_clk,
   input  logic                        bus_reset_l,
   output logic [`BUS_IN_WIDTH-1:0]    bus_in,
   input  logic [`BUS_OUT_WIDTH-1:0]   bus_out,

   input  logic                        m0_req,
   input  logic                        m0_we,
   input  logic [`BUS_ADDR_WIDTH-1:0]  m0_addr,
   input  logic [`BUS_DATA_WIDTH-1:0]  m0_wdata,
   output logic                        m0_ack,
   output logic [`BUS_DATA_WIDTH-1:0]  m0_rdata,
   output logic                        m0_err,

   input  logic                        m1_req,
   input  logic                        m1_we,
   input  logic [`BUS_ADDR_WIDTH-1:0]  m1_addr,
   input  logic [`BUS_DATA_WIDTH-1:0]  m1_wdata,
   output logic                        m1_ack,
   output logic [`BUS_DATA_WIDTH-1:0]  m1_rdata,
   output logic                        m1_err
);

   localparam int AW = `BUS_ADDR_WIDTH;
   localparam int DW = `BUS_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t          state;
   logic            last;      // master granted most recently; 1 after reset so m0 wins the first tie
   logic            grant;     // master owning the current transaction
   logic            we;        // direction of the current transaction
   logic            rd_req;
   logic            wr_req;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;

   // Slave return fields
   logic            rd_ack;
   logic            wr_ack;
   logic [DW-1:0]   rdata;
   logic            ack_match;

   // Grant selection
   logic            pick;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   assign rd_ack = bus_out[`BUS_OUT_RD_ACK];
   assign wr_ack = bus_out[`BUS_OUT_WR_ACK];
   assign rdata  = bus_out[`BUS_OUT_RDATA_HI:`BUS_OUT_RDATA_LO];

   // Only the ack type matching the transaction direction completes it.
   assign ack_match = we ? wr_ack : rd_ack;

   // Single requester wins outright; on a tie the master not served last wins.
   always_comb begin
      pick = m1_req;
      if (m0_req && m1_req) begin
         pick = ~last;
      end
   end

   assign sel_we    = pick ? m1_we    : m0_we;
   assign sel_addr  = pick ? m1_addr  : m0_addr;
   assign sel_wdata = pick ? m1_wdata : m0_wdata;

   // Clock and reset are forwarded so slaves need only the one bus.
   always_comb begin
      bus_in                                        = '0;
      bus_in[`BUS_IN_CLK]                           = bus_clk;
      bus_in[`BUS_IN_RESET_L]                       = bus_reset_l;
      bus_in[`BUS_IN_RD_REQ]                        = rd_req;
      bus_in[`BUS_IN_WR_REQ]                        = wr_req;
      bus_in[`BUS_IN_ADDR_HI:`BUS_IN_ADDR_LO]       = addr;
      bus_in[`BUS_IN_WDATA_HI:`BUS_IN_WDATA_LO]     = wdata;
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]      cnt;
   logic            unused_bits;
   assign unused_bits = bus_out[`BUS_OUT_IRQ];
`else
   localparam logic [7:0] TMO_UNUSED = 8'(TIMEOUT);
   logic            unused_bits;
   assign unused_bits = bus_out[`BUS_OUT_IRQ] ^ (^TMO_UNUSED);
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   always_ff @(posedge bus_clk) begin
      if (!bus_reset_l) begin
         state    <= IDLE;
         last     <= 1'b1;
         grant    <= 1'b0;
         we       <= 1'b0;
         rd_req   <= 1'b0;
         wr_req   <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         cnt      <= '0;
         m0_err   <= 1'b0;
         m1_err   <= 1'b0;
`endif
      end else begin
         // Request strobes and completion flags are single-cycle pulses.
         rd_req <= 1'b0;
         wr_req <= 1'b0;
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         m0_err <= 1'b0;
         m1_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  grant  <= pick;
                  we     <= sel_we;
                  addr   <= sel_addr;
                  wdata  <= sel_wdata;
                  rd_req <= ~sel_we;
                  wr_req <= sel_we;
`ifdef BUS_ARB_TIMEOUT_EN
                  cnt    <= '0;
`endif
                  state  <= WAIT;
               end
            end

            WAIT: begin
               // A matching ack in the timeout cycle still completes normally.
               if (ack_match) begin
                  if (grant) begin
                     m1_ack <= 1'b1;
                     if (!we) begin
                        m1_rdata <= rdata;
                     end
                  end else begin
                     m0_ack <= 1'b1;
                     if (!we) begin
                        m0_rdata <= rdata;
                     end
                  end
                  state <= ACK;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               else if (cnt == TMO_LAST) begin
                  if (grant) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= '0;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= '0;
                  end
                  state <= ACK;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end

            ACK: begin
               // One dead cycle here keeps a still-high request from being
               // re-granted before the master has seen its ack.
               last  <= grant;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_req_onehot: assert property (@(posedge bus_clk) disable iff (!bus_reset_l)
      !(rd_req && wr_req));
   a_ack_onehot: assert property (@(posedge bus_clk) disable iff (!bus_reset_l)
      !(m0_ack && m1_ack));

endmodule

// File: tb/tb_bus_arb2.sv
// Self-checking bench for bus_arb2 with a behavioural register slave and an
// expected-completion scoreboard.
module tb_bus_arb2;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int IW = 48;
   localparam int OW = 35;
   localparam int I_RST   = 1;
   localparam int I_RD    = 2;
   localparam int I_WR    = 3;
   localparam int I_ADDR  = 4;
   localparam int I_WDATA = 16;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam int TMO = 15;
`else
   localparam int TMO = 255;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [IW-1:0] bus_in;
   logic [OW-1:0] bus_out;
   logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;

   always #5 clk = ~clk;

   bus_arb2 #(.TIMEOUT(TMO)) dut (
      .bus_clk(clk), .bus_reset_l(rst_n), .bus_in(bus_in), .bus_out(bus_out),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err)
   );

   // ---------------- behavioural slave ----------------
   // 0x000-0x0FF mapped; 0x10 is a split register (read side split_in, write side split_out).
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [DW-1:0] split_in = 32'h0000_1234;
   logic [DW-1:0] split_out;
   logic          wr_pulse, s_rd_ack, s_wr_ack, s_wrong;
   logic [DW-1:0] s_rdata;
   logic          pend;
   int            pend_cnt;
   logic [AW-1:0] pend_addr;
   int            ack_delay = 0;
   logic          inject_wrong = 1'b0;

   assign s_addr  = bus_in[I_ADDR +: AW];
   assign s_wdata = bus_in[I_WDATA +: DW];
   assign bus_out = {1'b1, s_wr_ack | s_wrong, s_rd_ack, s_rdata};

   function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] a);
      if (a == 12'h010) return split_in;
      return {20'hABCDE, a};
   endfunction

   always @(posedge clk) begin
      s_rd_ack <= 1'b0; s_wr_ack <= 1'b0; s_wrong <= 1'b0; s_rdata <= '0; wr_pulse <= 1'b0;
      if (!rst_n) begin
         pend <= 1'b0; pend_cnt <= 0; pend_addr <= '0; split_out <= '0;
      end else begin
         if (bus_in[I_RD] && s_addr < 12'h100) begin
            if (inject_wrong) s_wrong <= 1'b1;
            if (ack_delay == 0) begin
               s_rd_ack <= 1'b1; s_rdata <= rd_value(s_addr);
            end else begin
               pend <= 1'b1; pend_cnt <= ack_delay - 1; pend_addr <= s_addr;
            end
         end
         if (bus_in[I_WR] && s_addr < 12'h100) begin
            s_wr_ack <= 1'b1; wr_pulse <= 1'b1;
            if (s_addr == 12'h010) split_out <= s_wdata;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               pend <= 1'b0; s_rd_ack <= 1'b1; s_rdata <= rd_value(pend_addr);
            end else begin
               pend_cnt <= pend_cnt - 1;
            end
         end
      end
   end

   int m0_acks = 0, m1_acks = 0;
   always @(posedge clk) begin
      if (m0_ack) m0_acks <= m0_acks + 1;
      if (m1_ack) m1_acks <= m1_acks + 1;
   end

   // ---------------- scoreboard ----------------
   typedef struct { int m; logic [DW-1:0] rdata; logic err; } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] held_rdata [2];
   int            vectors = 0;
   int            miscompares = 0;

   // Expected completion for a transaction just issued; reads update the held value.
   task automatic push_exp(input int m, input logic w, input logic [AW-1:0] a);
      exp_t e;
      e.m = m; e.err = 1'b0;
      if (w) begin
         e.rdata = held_rdata[m];
      end else if (a < 12'h100) begin
         e.rdata = rd_value(a);
      end else begin
         e.rdata = '0; e.err = 1'b1;
      end
      held_rdata[m] = e.rdata;
      sb.push_back(e);
   endtask

   task automatic drive(input int m, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if (m == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
   endtask

   task automatic wait_ack(input int m, input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) begin cyc = i; break; end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus_in[IW-1:1] !== '0) begin
         miscompares++; $display("FAIL reset_bus_in: got %0h expected 0", bus_in[IW-1:1]);
      end
      vectors++;
      if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err});
      end
      vectors++;
      if ({m0_rdata, m1_rdata} !== '0) begin
         miscompares++; $display("FAIL reset_rdata: got %0h/%0h expected 0/0", m0_rdata, m1_rdata);
      end
      rst_n = 1'b1;
      held_rdata[0] = '0; held_rdata[1] = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus_in[I_WR:I_RD] !== 2'b00) begin
         miscompares++; $display("FAIL idle_no_req: got %b expected 00", bus_in[I_WR:I_RD]);
      end
   endtask

   task automatic test_tie;
      exp_t e;
      int rem[2];
      int done, guard, gm;
      logic [DW-1:0] got;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      held_rdata[0] = '0; held_rdata[1] = '0;
      drive(0, 1'b1, 1'b0, 12'h020, '0);
      drive(1, 1'b1, 1'b0, 12'h024, '0);
      for (int k = 0; k < 6; k++) push_exp(k % 2, 1'b0, (k % 2 == 0) ? 12'h020 : 12'h024);
      rem[0] = 3; rem[1] = 3; done = 0; guard = 0;
      while (done < 6 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (m0_ack && m1_ack) begin
            vectors++; miscompares++;
            $display("FAIL tie_double_ack: got both acks expected one");
            done = 6;
         end else if (m0_ack || m1_ack) begin
            gm  = m1_ack ? 1 : 0;
            got = gm ? m1_rdata : m0_rdata;
            vectors++;
            e = sb.pop_front();
            if (gm !== e.m || got !== e.rdata || (gm ? m1_err : m0_err) !== e.err) begin
               miscompares++;
               $display("FAIL tie_grant%0d: got m%0d data %0h expected m%0d data %0h", done, gm, got, e.m, e.rdata);
            end
            done++;
            rem[gm]--;
            if (rem[gm] == 0) drive(gm, 1'b0, 1'b0, '0, '0);
         end
      end
      vectors++;
      if (done != 6) begin
         miscompares++; $display("FAIL tie_timeout: got %0d completions expected 6", done);
      end
      drive(0, 1'b0, 1'b0, '0, '0); drive(1, 1'b0, 1'b0, '0, '0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_single_read;
      exp_t e;
      drive(0, 1'b1, 1'b0, 12'h010, '0);
      push_exp(0, 1'b0, 12'h010);
      @(negedge clk);   // T+1
      vectors++;
      if (bus_in[I_WR:I_RD] !== 2'b01 || bus_in[I_ADDR +: AW] !== 12'h010) begin
         miscompares++; $display("FAIL rd_issue: got req %b addr %0h expected 01 010", bus_in[I_WR:I_RD], bus_in[I_ADDR +: AW]);
      end
      @(negedge clk);   // T+2
      vectors++;
      if (bus_in[I_WR:I_RD] !== 2'b00 || m0_ack !== 1'b0) begin
         miscompares++; $display("FAIL rd_single_pulse: got req %b ack %b expected 00 0", bus_in[I_WR:I_RD], m0_ack);
      end
      @(negedge clk);   // T+3
      vectors++;
      if (m0_ack !== 1'b1) begin
         miscompares++; $display("FAIL rd_latency: got m0_ack %b expected 1", m0_ack);
      end else begin
         e = sb.pop_front();
         if (m0_rdata !== e.rdata || m0_err !== e.err || m1_ack !== 1'b0) begin
            miscompares++; $display("FAIL rd_data: got %0h err %b expected %0h err %b", m0_rdata, m0_err, e.rdata, e.err);
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      vectors++;
      if (m0_ack !== 1'b0 || m0_rdata !== 32'h0000_1234) begin
         miscompares++; $display("FAIL rd_hold: got ack %b data %0h expected 0 1234", m0_ack, m0_rdata);
      end
   endtask

   task automatic test_single_write;
      exp_t e;
      drive(1, 1'b1, 1'b1, 12'h010, 32'hCAFE_F00D);
      push_exp(1, 1'b1, 12'h010);
      @(negedge clk);   // T+1
      vectors++;
      if (bus_in[I_WR:I_RD] !== 2'b10 || bus_in[I_WDATA +: DW] !== 32'hCAFE_F00D) begin
         miscompares++; $display("FAIL wr_issue: got req %b wdata %0h expected 10 cafef00d", bus_in[I_WR:I_RD], bus_in[I_WDATA +: DW]);
      end
      @(negedge clk);   // T+2
      vectors++;
      if (wr_pulse !== 1'b1 || split_out !== 32'hCAFE_F00D) begin
         miscompares++; $display("FAIL wr_pulse: got pulse %b out %0h expected 1 cafef00d", wr_pulse, split_out);
      end
      @(negedge clk);   // T+3
      vectors++;
      if (m1_ack !== 1'b1) begin
         miscompares++; $display("FAIL wr_latency: got m1_ack %b expected 1", m1_ack);
      end else begin
         e = sb.pop_front();
         if (m1_rdata !== e.rdata || m1_err !== e.err) begin
            miscompares++; $display("FAIL wr_ack: got %0h err %b expected %0h err %b", m1_rdata, m1_err, e.rdata, e.err);
         end
      end
      drive(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
   endtask

   task automatic test_wrong_ack;
      exp_t e;
      int cyc;
      ack_delay = 3; inject_wrong = 1'b1;
      drive(0, 1'b1, 1'b0, 12'h030, '0);
      push_exp(0, 1'b0, 12'h030);
      wait_ack(0, 20, cyc);
      vectors++;
      if (cyc != 6) begin
         miscompares++; $display("FAIL wrong_ack_latency: got %0d expected 6", cyc);
      end else begin
         e = sb.pop_front();
         if (m0_rdata !== e.rdata || m0_err !== e.err) begin
            miscompares++; $display("FAIL wrong_ack_data: got %0h expected %0h", m0_rdata, e.rdata);
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      ack_delay = 0; inject_wrong = 1'b0;
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait;
      exp_t e;
      int cyc, acks0;
      ack_delay = 4;
      drive(0, 1'b1, 1'b0, 12'h010, '0);
      repeat (2) @(negedge clk);   // now in WAIT
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus_in[IW-1:1] !== '0 || {m0_ack, m1_ack, m0_err, m1_err} !== 4'b0 || {m0_rdata, m1_rdata} !== '0) begin
         miscompares++; $display("FAIL midreset_outputs: got bus %0h m0 %0h m1 %0h expected all 0", bus_in[IW-1:1], m0_rdata, m1_rdata);
      end
      acks0 = m0_acks;
      rst_n = 1'b1;
      held_rdata[0] = '0; held_rdata[1] = '0;
      push_exp(0, 1'b0, 12'h010);
      @(negedge clk);
      vectors++;
      if (bus_in[I_WR:I_RD] !== 2'b01) begin
         miscompares++; $display("FAIL midreset_reissue: got %b expected 01", bus_in[I_WR:I_RD]);
      end
      wait_ack(0, 20, cyc);
      vectors++;
      if (cyc != 6 || m0_acks != acks0) begin
         miscompares++; $display("FAIL midreset_ack: got latency %0d acks %0d expected 6 %0d", cyc, m0_acks, acks0);
      end else begin
         e = sb.pop_front();
         if (m0_rdata !== e.rdata || m0_err !== e.err) begin
            miscompares++; $display("FAIL midreset_data: got %0h expected %0h", m0_rdata, e.rdata);
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      ack_delay = 0;
      sb.delete();
      @(negedge clk);
   endtask

`ifdef BUS_ARB_TIMEOUT_EN
   task automatic test_timeout;
      exp_t e;
      int cyc;
      drive(0, 1'b1, 1'b0, 12'h7FC, '0);
      push_exp(0, 1'b0, 12'h7FC);
      wait_ack(0, 40, cyc);
      vectors++;
      if (cyc != TMO + 1) begin
         miscompares++; $display("FAIL tmo_latency: got %0d expected %0d", cyc, TMO + 1);
      end else begin
         e = sb.pop_front();
         if (m0_rdata !== e.rdata || m0_err !== e.err) begin
            miscompares++; $display("FAIL tmo_result: got %0h err %b expected %0h err %b", m0_rdata, m0_err, e.rdata, e.err);
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      sb.delete();
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 12'h010, '0);
      push_exp(1, 1'b0, 12'h010);
      wait_ack(1, 10, cyc);
      vectors++;
      if (cyc != 3) begin
         miscompares++; $display("FAIL tmo_next_latency: got %0d expected 3", cyc);
      end else begin
         e = sb.pop_front();
         if (m1_rdata !== e.rdata || m1_err !== e.err) begin
            miscompares++; $display("FAIL tmo_next_data: got %0h err %b expected %0h err %b", m1_rdata, m1_err, e.rdata, e.err);
         end
      end
      drive(1, 1'b0, 1'b0, '0, '0);
      sb.delete();
      @(negedge clk);
   endtask
`endif

   initial begin
      held_rdata[0] = '0; held_rdata[1] = '0;
      test_reset;
      test_tie;
      test_single_read;
      test_single_write;
      test_wrong_ack;
      test_reset_mid_wait;
`ifdef BUS_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
